// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and one-shot sequencer sharing the single-port data memory
// between the pipeline MEM stage (requester 0) and the debug/loader port (requester 1).
module dmem_arbiter #(
  parameter int size = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req0,
  input  logic            req1,
  input  logic            we0,
  input  logic            we1,
  input  logic [size-1:0] addr0,
  input  logic [size-1:0] addr1,
  input  logic [size-1:0] wdata0,
  input  logic [size-1:0] wdata1,
  output logic            gnt0,
  output logic            gnt1,
  output logic            done0,
  output logic            done1,
  output logic [size-1:0] rdata0,
  output logic [size-1:0] rdata1,
  output logic            memRead,
  output logic            memWrite,
  output logic [size-1:0] mem_addr,
  output logic [size-1:0] mem_wdata,
  input  logic [size-1:0] mem_rdata
);

  // state | meaning
  // IDLE  | memory quiet; pick a winner and latch its request
  // BUSY  | drive the latched access onto the memory for one edge
  // RESP  | done pulse to the winner; rotate priority
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            ptr_q, ptr_d;
  logic            win_q, win_d;
  logic            we_l_q, we_l_d;
  logic [size-1:0] addr_l_q, addr_l_d;
  logic [size-1:0] wdata_l_q, wdata_l_d;
  logic [size-1:0] rdata0_q, rdata0_d;
  logic [size-1:0] rdata1_q, rdata1_d;
  logic            sel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= 1'b0;
      win_q     <= 1'b0;
      we_l_q    <= 1'b0;
      addr_l_q  <= '0;
      wdata_l_q <= '0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      we_l_q    <= we_l_d;
      addr_l_q  <= addr_l_d;
      wdata_l_q <= wdata_l_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  // A lone requester wins outright; on a tie the pointer decides.
  assign sel = (req0 && req1) ? ptr_q : req1;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    we_l_d    = we_l_q;
    addr_l_d  = addr_l_q;
    wdata_l_d = wdata_l_q;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    memRead   = 1'b0;
    memWrite  = 1'b0;
    done0     = 1'b0;
    done1     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          win_d     = sel;
          we_l_d    = sel ? we1 : we0;
          addr_l_d  = sel ? addr1 : addr0;
          wdata_l_d = sel ? wdata1 : wdata0;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        memRead  = !we_l_q;
        memWrite = we_l_q;
        if (!we_l_q) begin
          if (win_q) rdata1_d = mem_rdata;
          else       rdata0_d = mem_rdata;
        end
        state_d = RESP;
      end
      RESP: begin
        done0   = !win_q;
        done1   = win_q;
        ptr_d   = !win_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Address/data come straight from the latch so they hold outside BUSY.
  assign mem_addr  = addr_l_q;
  assign mem_wdata = wdata_l_q;
  assign gnt0      = (state_q != IDLE) && !win_q;
  assign gnt1      = (state_q != IDLE) && win_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer in front of the single-port `dataMem`. It lets the pipeline MEM stage (requester 0) and the debug/loader port (requester 1) share one data memory. Each transaction is granted round-robin, latched, driven onto the memory for one cycle, and completed with a one-cycle done pulse carrying registered read data.

## Interface
- `size`, 32, width of address and data buses (matches `dataMem`)
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `req0`, `req1`  in  1  transaction request from requester 0/1; held high until its done
- `we0`, `we1`  in  1  1 = write, 0 = read; sampled with req
- `addr0`, `addr1`  in  size  byte address; sampled with req
- `wdata0`, `wdata1`  in  size  write data; sampled with req
- `gnt0`, `gnt1`  out  1  requester owns the memory (BUSY and RESP)
- `done0`, `done1`  out  1  one-cycle completion pulse
- `rdata0`, `rdata1`  out  size  last read result per requester
- `memRead`, `memWrite`  out  1  to `dataMem`
- `mem_addr`, `mem_wdata`  out  size  to `dataMem` address/writeData
- `mem_rdata`  in  size  from `dataMem` out

## Operation
- State machine has 3 states.
  - IDLE: memRead = memWrite = 0. If any req is high at a rising edge, select a winner, latch its we/addr/wdata into internal registers and the winner index, then go to BUSY. If no req is high, stay in IDLE.
  - BUSY: drive `mem_addr`/`mem_wdata` from the latched registers. memRead = !we_l and memWrite = we_l. At the closing edge, a read captures `mem_rdata` into rdata of the winner, and a write commits in `dataMem` on that edge. Then go to RESP.
  - RESP: done of the winner = 1, memRead = memWrite = 0. Update the priority pointer, then go to IDLE unconditionally.
- Arbitration:
  - The priority pointer `ptr` resets to 0.
  - If only one req is high, that requester wins.
  - If both are high, requester `ptr` wins.
  - On leaving RESP, `ptr` is set to the non-winner, so continuous requests from both sides alternate and neither starves.
- Handshake:
  - A requester holds req, we, addr and wdata stable from assertion until it samples done = 1.
  - It deasserts req on that same edge, or keeps it high to issue a new transaction, which is evaluated in the following IDLE.
  - req is ignored in BUSY and RESP.
- Outputs:
  - memRead/memWrite and done0/1 are decoded combinationally from state and latched registers.
  - gntN = (state != IDLE) && winner == N.
  - `mem_addr`/`mem_wdata` hold their last latched value outside BUSY.
  - rdataN changes only on completion of a read by requester N. A write leaves it unchanged.
- Width: no arithmetic. All address and data paths are exactly `size` bits, passed through unmodified.

## Timing
- Reset (asynchronous, takes effect immediately):
  - state = IDLE, ptr = 0, winner = 0.
  - Latched we/addr/wdata = 0, rdata0 = rdata1 = 0.
  - All outputs are 0.
- Reset mid-operation: if asserted in BUSY, memWrite drops combinationally at once, no done is issued, and the transaction is discarded. The requester must reissue it after reset.
- Latency:
  - With req sampled at edge E (in IDLE), BUSY spans E..E+1 and RESP spans E+1..E+2.
  - done is high for exactly one cycle, beginning at edge E+1.
  - rdata is valid from edge E+1 onward.
- Throughput: one transaction per 3 cycles when requests are back-to-back.
- Simultaneous events:
  - Both reqs rising on the same edge: the winner is decided by `ptr`. The loser keeps requesting and is served next.
  - A req arriving during BUSY/RESP waits for IDLE.
- Memory contract: `dataMem` writes on the rising clk edge and reads combinationally. The arbiter guarantees memWrite is high for exactly one rising edge per write transaction.

## Test plan
- Reset: assert reset for 2 cycles with req0 = req1 = 1 → all outputs 0, no memRead/memWrite pulse; release reset → requester 0 is granted first.
- Write then read (requester 0): write addr 0, data 2; done0 pulses 2 cycles after req. Then read addr 0 → rdata0 = 2 when done0 = 1, memRead high for exactly 1 cycle.
- Contention: req0 and req1 held continuously, writing 0xA and 0xB to addresses 4 and 8 respectively → grants alternate 0,1,0,1 and done pulses come every 3 cycles. Reads back return 0xA and 0xB.
- rdata isolation: requester 1 reads addr 4 (0xA), then requester 0 writes addr 4 = 0x55 → rdata1 stays 0xA and rdata0 is unchanged.
- Reset mid-write: requester 1 writes 0xFF to addr 12; assert reset during BUSY → memWrite falls immediately, no done1. A subsequent read of addr 12 returns the prior value, not 0xFF (reset pulse aligned so no write edge occurs).
- Idle stability: no reqs for 10 cycles → memRead = memWrite = 0, gnt/done = 0, and rdata0/1 are unchanged.
